// File: rtl/data_ram_resp.sv
// data_ram_resp: word-addressed data RAM responder with wait states, byte-lane writes and error response.
// Define DATA_RAM_TRACE_EN to print one simulation line per response.
module data_ram_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  sel_i,
    output logic        ready_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d, sel_q, sel_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic we_q, we_d, ready_q, ready_d, err_q, err_d;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic bad, fire;
    assign idx  = addr_q[ADDR_WIDTH+1:2];
    assign bad  = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
    assign fire = (state_q == BUSY) && (cnt_q == 4'd0);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (req_i) begin
                addr_d  = addr_i;
                we_d    = we_i;
                wdata_d = wdata_i;
                sel_d   = sel_i;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = BUSY;
            end
            BUSY: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                ready_d = 1'b1;
                err_d   = bad;
                rdata_d = (bad || we_q) ? 32'd0 : mem[idx];
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end
    // Array is never reset; reset forces IDLE so an abandoned request cannot write.
    always_ff @(posedge clk) begin
        if (fire && we_q && !bad)
            for (int i = 0; i < 4; i++)
                if (sel_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
`ifdef DATA_RAM_TRACE_EN
    always @(posedge clk) begin
        if (rst && fire)
            $display("%0t data_ram_resp %s addr=%h sel=%b data=%h%s", $time, we_q ? "W" : "R",
                     addr_q, sel_q, we_q ? wdata_q : mem[idx], bad ? " ERR" : "");
    end
`endif
    assign ready_o = ready_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: directed bench driving three instances (WAIT_CYCLES 1, 0, 3) with shared stimulus.
module tb_data_ram_resp;
    logic clk = 1'b0, rst = 1'b1, req_i = 1'b0, we_i = 1'b0;
    logic [31:0] addr_i = 32'd0, wdata_i = 32'd0;
    logic [3:0] sel_i = 4'd0;
    logic rdy [3];
    logic er [3];
    logic [31:0] rdt [3];
    int exp_lat [3] = '{2, 1, 4};
    int lat [3], nr [3];
    logic [31:0] rd [3];
    logic ef [3];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .sel_i(sel_i), .ready_o(rdy[0]), .rdata_o(rdt[0]), .err_o(er[0]));
    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .sel_i(sel_i), .ready_o(rdy[1]), .rdata_o(rdt[1]), .err_o(er[1]));
    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .sel_i(sel_i), .ready_o(rdy[2]), .rdata_o(rdt[2]), .err_o(er[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s[%0d] ready", tag, k), {31'd0, rdy[k]}, 32'd0);
            chk($sformatf("%s[%0d] err", tag, k), {31'd0, er[k]}, 32'd0);
        end
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        we_i = w; addr_i = a; wdata_i = d; sel_i = s; req_i = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b0; we_i = ~w; addr_i = 32'hFFFF_FFFF; wdata_i = ~d; sel_i = ~s;
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0; nr[k] = 0; rd[k] = 32'hBAD0_BAD0; ef[k] = 1'b0;
        end
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++)
                if (rdy[k]) begin
                    nr[k]++; lat[k] = e; rd[k] = rdt[k]; ef[k] = er[k];
                end
        end
    endtask

    task automatic resp(input string tag, input logic e_err, input logic [31:0] e_rd);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s[%0d] latency", tag, k), lat[k], exp_lat[k]);
            chk($sformatf("%s[%0d] pulses", tag, k), nr[k], 32'd1);
            chk($sformatf("%s[%0d] err", tag, k), {31'd0, ef[k]}, {31'd0, e_err});
            chk($sformatf("%s[%0d] rdata", tag, k), rd[k], e_rd);
            chk($sformatf("%s[%0d] rdata hold", tag, k), rdt[k], e_rd);
        end
    endtask

    initial begin
        #2 rst = 1'b0; req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; wdata_i = 32'hFFFF_FFFF; sel_i = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            idle_chk($sformatf("reset c%0d", c));
            for (int k = 0; k < 3; k++) chk($sformatf("reset c%0d[%0d] rdata", c, k), rdt[k], 32'd0);
        end
        req_i = 1'b0; #3 rst = 1'b1;
        @(posedge clk); #1 idle_chk("post reset");

        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF); resp("wr 0x10", 1'b0, 32'd0);
        xact(1'b0, 32'h10, 32'd0, 4'h0);         resp("rd 0x10", 1'b0, 32'hDEAD_BEEF);
        xact(1'b1, 32'h20, 32'h1122_3344, 4'hF); resp("wr 0x20", 1'b0, 32'd0);
        xact(1'b1, 32'h20, 32'h0000_00AA, 4'h1); resp("wr b0", 1'b0, 32'd0);
        xact(1'b1, 32'h20, 32'hBB00_0000, 4'h8); resp("wr b3", 1'b0, 32'd0);
        xact(1'b0, 32'h20, 32'd0, 4'h3);         resp("rd 0x20", 1'b0, 32'hBB22_33AA);
        xact(1'b0, 32'h22, 32'd0, 4'hF);         resp("rd misaligned", 1'b1, 32'd0);
        xact(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);  resp("wr 0x0", 1'b0, 32'd0);
        xact(1'b1, 32'h1000, 32'h9999_9999, 4'hF); resp("wr oor", 1'b1, 32'd0);
        xact(1'b0, 32'h0, 32'd0, 4'h0);          resp("rd 0x0", 1'b0, 32'hCAFE_F00D);
        xact(1'b1, 32'h10, 32'h0, 4'h0);         resp("wr sel0", 1'b0, 32'd0);
        xact(1'b0, 32'h10, 32'd0, 4'h0);         resp("rd after sel0", 1'b0, 32'hDEAD_BEEF);
        xact(1'b1, 32'h30, 32'h1234_5678, 4'hF); resp("wr 0x30", 1'b0, 32'd0);

        we_i = 1'b1; addr_i = 32'h30; wdata_i = 32'h5555_5555; sel_i = 4'hF; req_i = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b0; rst = 1'b0;
        #1 idle_chk("abort asserted");
        @(posedge clk); #1 idle_chk("abort held");
        #3 rst = 1'b1;
        @(posedge clk); #1 idle_chk("abort released");
        @(posedge clk); #1 idle_chk("abort idle");
        xact(1'b0, 32'h30, 32'd0, 4'h0);         resp("rd 0x30 after abort", 1'b0, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Word-addressed on-chip data memory acting as the responder on the core's load/store request bus in the minimal SOPC.
- Accepts one request at a time, inserts a configurable number of wait states, then returns a single-cycle ready pulse with read data or an error flag.
- Supports byte-lane writes for SB/SH/SW. The core side does any sign/zero extension.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH 32-bit words (4 KiB default).
- WAIT_CYCLES, 1, extra cycles between request accept and response (0..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low: asserted when 0, released synchronously by the system.
- req_i  input  1  request valid, sampled only in IDLE.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address.
- wdata_i  input  32  write data, little-endian lanes.
- sel_i  input  4  byte enables; bit i selects wdata_i[8i+7:8i].
- ready_o  output  1  one-cycle response strobe.
- rdata_o  output  32  read data, valid when ready_o=1.
- err_o  output  1  error flag, valid only with ready_o.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, ready_o=0, err_o=0, rdata_o=0.
  - Memory array is not reset; contents are unchanged across reset.
  - Reset mid-request abandons the request; no write occurs.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_i=1 at a rising edge: latch addr/we/wdata/sel, load counter with WAIT_CYCLES, go to BUSY.
  - Inputs are don't-care after the accept edge.
- BUSY:
  - counter != 0: decrement.
  - counter == 0: perform the access, set ready_o=1, go to RESP.
- RESP:
  - ready_o=0 and err_o=0 on the next edge, go to IDLE.
  - req_i is ignored in RESP, which gives one mandatory turnaround cycle.
- Latency: ready_o rises WAIT_CYCLES+1 edges after the accept edge.
  - Back-to-back throughput is one request per WAIT_CYCLES+3 cycles.
- Initiator protocol: deassert req_i in the cycle ready_o=1, or hold it to issue a new request that is accepted in the following IDLE.
- Error conditions, checked on latched values:
  - addr[1:0] != 0 (misaligned).
  - addr[31:ADDR_WIDTH+2] != 0 (out of range).
  - On error: ready_o=1, err_o=1, rdata_o=0, no memory write.
- Write (no error): for each i with sel[i]=1, mem[addr[ADDR_WIDTH+1:2]] byte i <= wdata byte i; other bytes unchanged.
  - rdata_o <= 0, err_o=0.
  - sel=0000 is legal: response issued, memory unchanged.
- Read (no error): rdata_o <= full stored word at the response edge. sel is ignored for reads.
- rdata_o holds its last value between responses.
- A read immediately after a write to the same word returns the updated data.

Optional Feature:
- Macro: DATA_RAM_TRACE_EN.
- Defined: each response edge prints one simulation line with $time, R/W, address, sel, data (write data, or read data), and ERR if flagged. Non-synthesizable; guarded by the macro.
- Undefined: no trace code is compiled; functional behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_i=1 -> ready_o=0, err_o=0, rdata_o=0 throughout; nothing is accepted until rst=1.
- Full-word write then read, WAIT_CYCLES=1:
  - Write 0xDEADBEEF to 0x10, sel=1111 -> ready_o rises exactly 2 edges after accept, err_o=0.
  - Read 0x10 -> rdata_o=0xDEADBEEF.
- Byte-lane merge:
  - Write 0x11223344 to 0x20, sel=1111.
  - Write 0x000000AA, sel=0001.
  - Write 0xBB000000, sel=1000.
  - Read 0x20 -> 0xBB2233AA.
- Misaligned address: read 0x22 -> ready_o=1, err_o=1, rdata_o=0.
- Out-of-range address: write 0x00001000 (ADDR_WIDTH=10) -> err_o=1; subsequent read of 0x0 returns its prior value unchanged.
- Reset mid-request: accept write 0x55555555 to 0x30, pull rst=0 while in BUSY, release, then read 0x30 -> prior contents, not 0x55555555. Run with WAIT_CYCLES=0 and WAIT_CYCLES=3 and confirm latencies of 1 and 4 edges.
